// File: rtl/irq_arbiter_pkg.sv
// Shared constants and types for the platform interrupt arbiter: source IDs
// matching the trap codes, register offsets, and the gateway state encoding.
package irq_arbiter_pkg;

  typedef logic [3:0] irq_id_t;

  localparam int unsigned PRIO_W_DEF = 3;
  typedef logic [PRIO_W_DEF-1:0] prio_t;

  localparam irq_id_t IRQ_NONE    = 4'd0;
  localparam irq_id_t IRQ_UART0RX = 4'd1;
  localparam irq_id_t IRQ_UART0TX = 4'd2;
  localparam irq_id_t IRQ_TIM0    = 4'd3;
  localparam irq_id_t IRQ_TIM1    = 4'd4;
  localparam irq_id_t IRQ_GPIOA0  = 4'd5;
  localparam irq_id_t IRQ_GPIOA1  = 4'd6;
  localparam irq_id_t IRQ_GPIOB0  = 4'd7;
  localparam irq_id_t IRQ_GPIOB1  = 4'd8;
  localparam irq_id_t IRQ_GPIOC0  = 4'd9;
  localparam irq_id_t IRQ_GPIOC1  = 4'd10;

  localparam logic [7:0] OFS_PENDING   = 8'h40;
  localparam logic [7:0] OFS_ENABLE    = 8'h44;
  localparam logic [7:0] OFS_THRESHOLD = 8'h48;
  localparam logic [7:0] OFS_CLAIM     = 8'h4C;
  localparam logic [7:0] OFS_EDGE_SEL  = 8'h50;

  // Word indices (byte offset >> 2) used by the address decoder.
  localparam logic [5:0] W_PENDING   = OFS_PENDING[7:2];
  localparam logic [5:0] W_ENABLE    = OFS_ENABLE[7:2];
  localparam logic [5:0] W_THRESHOLD = OFS_THRESHOLD[7:2];
  localparam logic [5:0] W_CLAIM     = OFS_CLAIM[7:2];
  localparam logic [5:0] W_EDGE_SEL  = OFS_EDGE_SEL[7:2];

  // Encoding is {pending, in_service}.
  typedef enum logic [1:0] {
    GW_IDLE       = 2'b00,
    GW_IN_SERVICE = 2'b01,
    GW_PENDING    = 2'b10
  } gw_state_t;

endpackage

// File: rtl/irq_arbiter_if.sv
// Memory-mapped register bus between firmware-facing bridge and the arbiter.
interface irq_arbiter_if;
  logic        reg_rd_en;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;

  modport master (
    output reg_rd_en, reg_wr_en, reg_addr, reg_wr_data,
    input  reg_rd_data
  );

  modport slave (
    input  reg_rd_en, reg_wr_en, reg_addr, reg_wr_data,
    output reg_rd_data
  );
endinterface

// File: rtl/irq_arbiter_gateway.sv
// Per-source interrupt gateway: latches a request, blocks re-entry while in
// service. IRQ_ARBITER_EDGE_EN adds edge-mode detection and a deferred bit.
module irq_gateway
  import irq_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
`ifdef IRQ_ARBITER_EDGE_EN
  input  logic edge_mode,
`endif
  input  logic claim,
  input  logic complete,
  output logic pending
);

  gw_state_t state_q, state_d;
  logic      req;

`ifdef IRQ_ARBITER_EDGE_EN
  logic src_prev_q;
  logic deferred_q, deferred_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev_q <= '0;
      deferred_q <= '0;
    end else begin
      src_prev_q <= src;
      deferred_q <= deferred_d;
    end
  end

  assign req = edge_mode ? (src & ~src_prev_q) : src;
`else
  assign req = src;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= GW_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef IRQ_ARBITER_EDGE_EN
    deferred_d = deferred_q;
`endif
    unique case (state_q)
      GW_IDLE:    if (req) state_d = GW_PENDING;
      GW_PENDING: if (claim) state_d = GW_IN_SERVICE;
      GW_IN_SERVICE: begin
`ifdef IRQ_ARBITER_EDGE_EN
        // An edge arriving in the completing cycle still counts as deferred.
        if (complete) begin
          state_d    = (deferred_q || (edge_mode && req)) ? GW_PENDING : GW_IDLE;
          deferred_d = 1'b0;
        end else if (edge_mode && req) begin
          deferred_d = 1'b1;
        end
`else
        if (complete) state_d = GW_IDLE;
`endif
      end
      default: state_d = GW_IDLE;
    endcase
  end

  assign pending = (state_q == GW_PENDING);

endmodule

// File: rtl/irq_arbiter.sv
// Platform interrupt arbiter: per-source gateways, priority/enable/threshold
// registers, registered arbitration and claim/complete. Optional edge-triggered
// sources are built with IRQ_ARBITER_EDGE_EN.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 10,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  irq_arbiter_if.slave       reg_bus,
  output logic               ext_irq
);

  logic [PRIO_W-1:0]  prio_q [16];
  logic [PRIO_W-1:0]  prio_d [16];
  logic [NUM_SRC:1]   enable_q, enable_d;
  logic [PRIO_W-1:0]  threshold_q, threshold_d;
  irq_id_t            best_id_q, best_id_d;
  logic               ext_irq_q, ext_irq_d;

  logic [NUM_SRC:1]   pend_vec;
  logic [NUM_SRC:1]   claim_vec;
  logic [NUM_SRC:1]   complete_vec;
  logic [15:0]        pend_full;
  logic [15:0]        en_full;
  logic [PRIO_W-1:0]  arb_prio;
  irq_id_t            claim_id;
  logic [5:0]         word;
  logic               prio_sel;
  logic               claim_fire;
  logic               complete_wr;
  logic [31:0]        rd_data;
  logic               unused_bus_bits;

  assign word            = reg_bus.reg_addr[7:2];
  assign prio_sel        = (word != '0) && (32'(word) <= NUM_SRC);
  assign unused_bus_bits = ^{reg_bus.reg_addr[1:0], reg_bus.reg_wr_data};

`ifdef IRQ_ARBITER_EDGE_EN
  logic [NUM_SRC:1] edge_sel_q, edge_sel_d;
  logic [15:0]      edge_full;

  always_ff @(posedge clk) begin
    if (rst) edge_sel_q <= '0;
    else     edge_sel_q <= edge_sel_d;
  end

  always_comb begin
    edge_sel_d = edge_sel_q;
    if (reg_bus.reg_wr_en && word == W_EDGE_SEL)
      edge_sel_d = reg_bus.reg_wr_data[NUM_SRC:1];
    edge_full = '0;
    edge_full[NUM_SRC:1] = edge_sel_q;
  end
`endif

  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_src
    assign claim_vec[g]    = claim_fire && (best_id_q == irq_id_t'(g));
    assign complete_vec[g] = complete_wr && (reg_bus.reg_wr_data[3:0] == irq_id_t'(g));

    irq_gateway u_gw (
      .clk       (clk),
      .rst       (rst),
      .src       (src_irq[g-1]),
`ifdef IRQ_ARBITER_EDGE_EN
      .edge_mode (edge_sel_q[g]),
`endif
      .claim     (claim_vec[g]),
      .complete  (complete_vec[g]),
      .pending   (pend_vec[g])
    );
  end

  always_comb begin
    pend_full = '0;
    pend_full[NUM_SRC:1] = pend_vec;
    en_full = '0;
    en_full[NUM_SRC:1] = enable_q;
  end

  // Strict '>' keeps the lowest ID on ties and excludes priority 0.
  always_comb begin
    best_id_d = '0;
    arb_prio  = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (pend_full[i[3:0]] && en_full[i[3:0]] && (prio_q[i[3:0]] > arb_prio)) begin
        best_id_d = irq_id_t'(i);
        arb_prio  = prio_q[i[3:0]];
      end
    end
    ext_irq_d = (best_id_d != '0) && (arb_prio > threshold_q);
  end

  // Claim uses the registered winner, revalidated against live pending/enable.
  always_comb begin
    claim_id = '0;
    if (best_id_q != '0 && pend_full[best_id_q] && en_full[best_id_q])
      claim_id = best_id_q;
  end

  assign claim_fire  = reg_bus.reg_rd_en && (word == W_CLAIM) && (claim_id != '0);
  assign complete_wr = reg_bus.reg_wr_en && (word == W_CLAIM);

  always_comb begin
    prio_d      = prio_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
    if (reg_bus.reg_wr_en) begin
      if (prio_sel) prio_d[word[3:0]] = reg_bus.reg_wr_data[PRIO_W-1:0];
      case (word)
        W_ENABLE:    enable_d    = reg_bus.reg_wr_data[NUM_SRC:1];
        W_THRESHOLD: threshold_d = reg_bus.reg_wr_data[PRIO_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= '{default: '0};
      enable_q    <= '0;
      threshold_q <= '0;
      best_id_q   <= '0;
      ext_irq_q   <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      best_id_q   <= best_id_d;
      ext_irq_q   <= ext_irq_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (reg_bus.reg_rd_en) begin
      if (prio_sel) begin
        rd_data[PRIO_W-1:0] = prio_q[word[3:0]];
      end else begin
        case (word)
          W_PENDING:   rd_data[15:0]       = pend_full;
          W_ENABLE:    rd_data[15:0]       = en_full;
          W_THRESHOLD: rd_data[PRIO_W-1:0] = threshold_q;
          W_CLAIM:     rd_data[3:0]        = claim_id;
`ifdef IRQ_ARBITER_EDGE_EN
          W_EDGE_SEL:  rd_data[15:0]       = edge_full;
`endif
          default: ;
        endcase
      end
    end
  end

  assign reg_bus.reg_rd_data = rd_data;
  assign ext_irq             = ext_irq_q;

endmodule
